// File: rtl/rca4_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rca4 / rca4_serial_add_ctrl
// Description : Nibble-serial WIDTH-bit adder/subtractor built on one 4-bit
//               ripple-carry slice. One nibble per clock, LSB nibble first,
//               with valid/ready handshakes on operands and result.
// Revision    : 1.0 - initial release
// ============================================================================

// 4-bit ripple-carry slice, purely combinational.
module rca4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       c_o
);
    logic [4:0] w_carry;

    assign w_carry[0] = c_i;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum_o[i]       = a_i[i] ^ b_i[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = w_carry[4];
endmodule

module rca4_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    // Reject widths that do not split into whole nibbles.
    if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("rca4_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;      // already inverted for subtraction
    logic [WIDTH-1:0] sum_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;

    logic [3:0]       w_slice_a;
    logic [3:0]       w_slice_b;
    logic [3:0]       w_slice_sum;
    logic             w_slice_cout;

    assign w_slice_a = opa_q[4*idx_q +: 4];
    assign w_slice_b = opb_q[4*idx_q +: 4];

    rca4 u_slice (
        .a_i   (w_slice_a),
        .b_i   (w_slice_b),
        .c_i   (carry_q),
        .sum_o (w_slice_sum),
        .c_o   (w_slice_cout)
    );

    // Control FSM plus datapath registers: accept, walk nibbles, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // in_ready is high here whenever rst is low
                    if (in_valid) begin
                        opa_q   <= a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : c_in;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[4*idx_q +: 4] <= w_slice_sum;
                    carry_q             <= w_slice_cout;
                    if (idx_q == LAST_IDX) begin
                        // Top nibble: capture carry and signed overflow.
                        idx_q   <= '0;
                        cout_q  <= w_slice_cout;
                        ovf_q   <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                                   (w_slice_sum[3] != opa_q[WIDTH-1]);
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign sum       = sum_q;
    assign c_out     = cout_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: doc/rca4_serial_add_ctrl.md
Name: rca4_serial_add_ctrl

Overview:
- Multi-cycle wide adder/subtractor built around a single instance of the existing 4-bit ripple-carry slice RCA4.
- Processes one nibble per clock, least-significant nibble first, with the slice carry-out registered and fed back as the next nibble's carry-in.
- Gives WIDTH-bit add/sub at 4-bit-slice area cost, for blocks that trade latency for area.
- Operands enter on a valid/ready handshake; results leave on a second valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and ≥4; any other value is a configuration error.
- NIB, WIDTH/4, number of nibble steps (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- c_in  input  1  carry-in for add; ignored when sub=1
- sub  input  1  1 = compute a - b
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- c_out  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  two's-complement signed overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, active-high):
  - state=IDLE, nibble index=0, carry reg=0.
  - sum=0, c_out=0, overflow=0, out_valid=0, busy=0.
  - in_ready=0 while rst is high.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On a clk edge with in_valid & in_ready:
    - Latch a into opA.
    - Latch opB = sub ? ~b : b.
    - carry reg = sub ? 1 : c_in.
    - idx=0, clear the sum register, go to RUN.
  - in_valid while not in IDLE is ignored. Operands are not sampled outside the handshake edge.
- RUN:
  - Slice inputs: opA[4*idx+:4], opB[4*idx+:4], carry reg.
  - Each edge:
    - sum_reg[4*idx+:4] <= slice sum.
    - carry reg <= slice c_out.
    - idx <= idx+1.
  - On the edge where idx==NIB-1:
    - c_out <= slice c_out.
    - overflow <= (opA[WIDTH-1]==opB[WIDTH-1]) && (slice sum bit 3 != opA[WIDTH-1]).
    - Go to DONE.
  - Exactly NIB RUN cycles. No early termination.
- DONE:
  - out_valid=1.
  - sum, c_out and overflow are stable until the handshake completes.
  - On an edge with out_ready=1: out_valid drops, go to IDLE.
  - out_ready low holds DONE indefinitely. out_ready outside DONE is ignored.
- Outputs:
  - sum, c_out and overflow are registered.
  - In IDLE they retain the last result until the next accept clears sum.
  - out_valid, in_ready and busy decode from state.
- Latency:
  - Accept at edge 0; out_valid is high after edge NIB (4 cycles for WIDTH=16).
  - out_ready high on that first DONE cycle gives a return to IDLE after edge NIB+1.
  - Throughput is one operation per NIB+2 cycles at best. in_ready and out_valid are never high together.
- Width rules:
  - All arithmetic is modulo 2^WIDTH.
  - idx counter width is clog2(NIB), minimum 1 bit. idx wraps to 0 on entry to DONE.
- Reset mid-operation (RUN or DONE):
  - Aborts immediately; the partial result is discarded and out_valid drops asynchronously.
  - No output handshake for the aborted operation.
- The RCA4 slice is purely combinational. All state lives in this block.

Test Plan:
- Simple add: WIDTH=16, a=0x00FF, b=0x0001, c_in=0, sub=0 → out_valid exactly 4 cycles after accept; sum=0x0100, c_out=0, overflow=0.
- Wrap and carry-in:
  - a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, overflow=0.
  - a=0x1234, b=0x1111, c_in=1 → sum=0x2346.
- Subtract and signed overflow:
  - sub=1, a=0x0005, b=0x0007, c_in=1 (ignored) → sum=0xFFFE, c_out=0, overflow=0.
  - a=0x7FFF+0x0001 → sum=0x8000, overflow=1, c_out=0.
  - sub=1, 0x8000-0x0001 → sum=0x7FFF, overflow=1, c_out=1.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid, driving in_valid=1 with new operands throughout → out_valid held, sum/c_out stable, in_ready=0, new operands not captured; after out_ready=1 the block returns to IDLE and then accepts the pending bundle.
- Reset mid-RUN: assert rst at idx=2 of a 0x1234+0x4321 operation → out_valid=0, busy=0, in_ready=0 during rst; after release in_ready=1, no result handshake for the aborted op; a following 0x0001+0x0001 yields sum=0x0002.
- Back-to-back with out_ready tied 1: 8 random add/sub operations (WIDTH=16, and repeated at WIDTH=4 and WIDTH=32) checked against a reference model → every result correct; spacing between accepts is NIB+2 cycles.
